approx_add_err_monitor: RTL and testbench
=========================================

// Module: approx_add_err_monitor
// PURPOSE
//  Streaming error monitor downstream of an approximate ripple-carry adder (N-bit ops, N+1-bit sum).
//  Takes each operand pair plus the adder's approximate sum and recomputes the exact sum.
//  Over a window of 2**SAMPLES_LOG2 samples it accumulates squared error, max |error| and the count of erroneous samples.
//  Results feed the area/MSE characterisation flow.
// PARAMETERS
//  WIDTH         8                         operand width; sums are WIDTH+1 bits
//  SAMPLES_LOG2  8                         window = 2**SAMPLES_LOG2 samples
//  ACC_W         2*(WIDTH+1)+SAMPLES_LOG2  squared-error accumulator width (overflow-free by construction)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst_n        in   1                 asynchronous active-low reset
//  start        in   1                 1-cycle pulse: clear stats, open window (honoured in IDLE only)
//  in_valid     in   1                 sample valid
//  in_ready     out  1                 sample accepted when in_valid & in_ready
//  op_a         in   WIDTH             operand A
//  op_b         in   WIDTH             operand B
//  approx_sum   in   WIDTH+1           approximate adder output for op_a, op_b
//  res_valid    out  1                 window results valid, held until res_ready
//  res_ready    in   1                 consumer accepts results
//  sum_sq_err   out  ACC_W             sum of (approx_sum - (op_a+op_b))**2
//  max_abs_err  out  WIDTH+1           max |approx_sum - exact|
//  err_count    out  SAMPLES_LOG2+1    samples with nonzero error
//  busy         out  1                 high in any state except IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; in_ready=0; res_valid=0; busy=0.
//    - All accumulators, outputs, sample counter and pipeline valids = 0.
//  - FSM IDLE -> COLLECT on start.
//  - COLLECT -> FLUSH on the cycle the 2**SAMPLES_LOG2-th sample is accepted.
//  - FLUSH lasts exactly 2 cycles (pipeline drain) -> REPORT.
//  - REPORT -> IDLE on res_valid & res_ready.
//  - in_ready = 1 only in COLLECT (registered). Samples offered in other states are not consumed.
//  - start outside IDLE is ignored. start and res_ready handshake in the same cycle: IDLE entered, start ignored.
//  - Pipeline, 2 stages, advances every cycle:
//    - S1 registers err = $signed({1'b0,approx_sum}) - $signed({1'b0,op_a}+{1'b0,op_b}) (WIDTH+2 bits signed) and |err|.
//    - S2 adds err*err into sum_sq_err, updates max_abs_err, increments err_count if err!=0.
//  - Sample accepted in cycle t appears in outputs at t+2.
//  - Arithmetic:
//    - |err| <= 2**(WIDTH+1)-1 fits WIDTH+1 bits; err**2 fits 2*(WIDTH+1) bits.
//    - No saturation is needed. Sample counter is SAMPLES_LOG2+1 bits.
//  - res_valid rises on REPORT entry; sum_sq_err, max_abs_err and err_count are stable while res_valid=1.
//  - Stats clear on start (same cycle); they persist after REPORT until the next start.
//  - in_valid gaps in COLLECT are legal; the window closes on accepted-sample count, not cycles.
//  - Reset mid-window aborts it: no partial results, res_valid=0.
// CONFIGURATION
//  ERR_BIAS_EN defined:
//    - Adds output err_bias (signed, WIDTH+2+SAMPLES_LOG2 bits) = sum of signed err over the window.
//    - Same timing and clear rules as sum_sq_err; reset 0.
//  ERR_BIAS_EN undefined: port and logic absent; all other behaviour identical.
// TESTING (SAMPLES_LOG2=2, WIDTH=8 unless noted)
//  1 Exact: 4 samples a=3,b=5,approx=8 -> sum_sq_err=0, max_abs_err=0, err_count=0, res_valid once.
//  2 Worst case: 4 samples a=255,b=255,approx=0 -> sum_sq_err=4*260100=1040400, max_abs_err=510, err_count=4.
//  3 Mixed: errs +1,-2,0,+3 -> sum_sq_err=14, max_abs_err=3, err_count=3; ERR_BIAS_EN: err_bias=2.
//  4 Backpressure:
//    - in_valid toggling every other cycle -> window closes after 4th accepted sample.
//    - res_ready=0 for 10 cycles -> outputs and res_valid held; in_ready=0 throughout.
//  5 Protocol: start pulsed during COLLECT -> ignored, stats unchanged; start during REPORT -> ignored.
//  6 Reset after 2 samples -> all outputs 0 at once; new start + 4 samples gives stats of those 4 only.

Source files
------------

// File: rtl/approx_add_err_monitor.sv
// approx_add_err_monitor
// Streaming error monitor placed after an approximate adder. For each accepted
// operand pair it recomputes the exact sum and compares it with the adder output.
// Over a window of 2**SAMPLES_LOG2 accepted samples it accumulates:
//   - the squared error,
//   - the largest absolute error,
//   - the number of samples whose error is not zero.
// Optional feature: define ERR_BIAS_EN to add the err_bias output. It holds the
// signed sum of the errors over the window.
module approx_add_err_monitor #(
  parameter int WIDTH        = 8,
  parameter int SAMPLES_LOG2 = 8,
  parameter int ACC_W        = 2*(WIDTH+1)+SAMPLES_LOG2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                op_a,
  input  logic [WIDTH-1:0]                op_b,
  input  logic [WIDTH:0]                  approx_sum,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ACC_W-1:0]                sum_sq_err,
  output logic [WIDTH:0]                  max_abs_err,
  output logic [SAMPLES_LOG2:0]           err_count,
`ifdef ERR_BIAS_EN
  output logic signed [WIDTH+1+SAMPLES_LOG2:0] err_bias,
`endif
  output logic                            busy
);

  localparam int CNT_W = SAMPLES_LOG2 + 1;
  localparam int SQ_W  = 2 * (WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** SAMPLES_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_flush_cnt;
  logic [CNT_W-1:0]  r_sample_cnt;

  logic              w_accept;
  logic              w_last;
  logic              w_start_go;

  // Stage 1 registers: absolute error of the most recently accepted sample
  logic              r_s1_valid;
  logic [WIDTH:0]    r_s1_abs;

  // Window statistics
  logic [ACC_W-1:0]  r_sum_sq;
  logic [WIDTH:0]    r_max_abs;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [WIDTH:0]          w_exact;
  logic signed [WIDTH+1:0] w_err;
  logic [WIDTH:0]          w_abs;
  logic [SQ_W-1:0]         w_sq;

  // The state register drives the handshake outputs directly, so they are glitch-free.
  assign w_accept   = in_valid & in_ready;
  assign w_last     = w_accept && (r_sample_cnt == LAST_IDX);
  assign w_start_go = start && (r_state == ST_IDLE);

  // The error is computed one bit wider than the sums so that its sign is kept
  assign w_exact = {1'b0, op_a} + {1'b0, op_b};
  assign w_err   = $signed({1'b0, approx_sum}) - $signed({1'b0, w_exact});
  assign w_abs   = (WIDTH+1)'(w_err[WIDTH+1] ? -w_err : w_err);
  assign w_sq    = r_s1_abs * r_s1_abs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. FLUSH holds for two cycles while the pipeline drains.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start)                  w_state_next = ST_COLLECT;
      ST_COLLECT: if (w_last)                 w_state_next = ST_FLUSH;
      ST_FLUSH:   if (r_flush_cnt)            w_state_next = ST_REPORT;
      ST_REPORT:  if (res_valid && res_ready) w_state_next = ST_IDLE;
      default:                                w_state_next = ST_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    in_ready  = (r_state == ST_COLLECT);
    res_valid = (r_state == ST_REPORT);
    busy      = (r_state != ST_IDLE);
  end

  // Flush-cycle counter and accepted-sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt  <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_flush_cnt <= (r_state == ST_FLUSH) ? ~r_flush_cnt : 1'b0;
      if (w_start_go) begin
        r_sample_cnt <= '0;
      end else if (w_accept) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: register the absolute error of the accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_abs   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_abs <= w_abs;
      end
    end
  end

  // Stage 2: update the statistics. A start in IDLE clears them in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_sq  <= '0;
      r_max_abs <= '0;
      r_err_cnt <= '0;
    end else if (w_start_go) begin
      r_sum_sq  <= '0;
      r_max_abs <= '0;
      r_err_cnt <= '0;
    end else if (r_s1_valid) begin
      r_sum_sq <= r_sum_sq + ACC_W'(w_sq);
      if (r_s1_abs > r_max_abs) begin
        r_max_abs <= r_s1_abs;
      end
      if (r_s1_abs != '0) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign sum_sq_err  = r_sum_sq;
  assign max_abs_err = r_max_abs;
  assign err_count   = r_err_cnt;

`ifdef ERR_BIAS_EN
  localparam int BIAS_W = WIDTH + 2 + SAMPLES_LOG2;

  logic signed [WIDTH+1:0]  r_s1_err;
  logic signed [BIAS_W-1:0] r_bias;

  // Stage 1 copy of the signed error, used only by the bias accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_err <= '0;
    end else if (w_accept) begin
      r_s1_err <= w_err;
    end
  end

  // Stage 2 signed error sum. It is cleared and timed in the same way as sum_sq_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias <= '0;
    end else if (w_start_go) begin
      r_bias <= '0;
    end else if (r_s1_valid) begin
      r_bias <= r_bias + {{SAMPLES_LOG2{r_s1_err[WIDTH+1]}}, r_s1_err};
    end
  end

  assign err_bias = r_bias;
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Testbench for approx_add_err_monitor with WIDTH=8 and SAMPLES_LOG2=2.
// The bench computes the expected statistics of each window while it drives
// the samples. It queues these results and checks them when res_valid appears.
module tb_approx_add_err_monitor;

  localparam int WIDTH = 8;
  localparam int SL2   = 2;
  localparam int ACC_W = 2*(WIDTH+1)+SL2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH:0]    approx_sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  sum_sq_err;
  logic [WIDTH:0]    max_abs_err;
  logic [SL2:0]      err_count;
  logic              busy;
`ifdef ERR_BIAS_EN
  logic signed [WIDTH+1+SL2:0] err_bias;
`endif

  approx_add_err_monitor #(.WIDTH(WIDTH), .SAMPLES_LOG2(SL2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum_sq_err(sum_sq_err), .max_abs_err(max_abs_err), .err_count(err_count),
`ifdef ERR_BIAS_EN
    .err_bias(err_bias),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sq;
    int     mx;
    int     cnt;
    int     bias;
  } exp_t;

  exp_t   sb_q[$];
  int     compared = 0;
  int     mismatched = 0;
  longint m_sq;
  int     m_max, m_cnt, m_bias;
  longint last_sq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  task automatic model_clear();
    m_sq = 0; m_max = 0; m_cnt = 0; m_bias = 0;
  endtask

  // Pulse start for one cycle starting at a negedge. Returns at the next negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic open_window();
    pulse_start();
    model_clear();
    $display("start: window opened");
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_in_ready", 64'(in_ready), 64'd1);
    chk("start_clears_sq", 64'(sum_sq_err), 64'd0);
  endtask

  // Offer one sample and hold it until it is accepted, then update the model
  task automatic send(input int a, input int b, input int s);
    int err, cyc;
    op_a = 8'(a); op_b = 8'(b); approx_sum = 9'(s);
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    err = s - (a + b);
    m_sq += longint'(err) * longint'(err);
    if ((err < 0 ? -err : err) > m_max) m_max = (err < 0 ? -err : err);
    if (err != 0) m_cnt++;
    m_bias += err;
    $display("sample: a=%0d b=%0d approx=%0d err=%0d", a, b, s, err);
  endtask

  task automatic push_expected();
    exp_t e;
    e.sq = m_sq; e.mx = m_max; e.cnt = m_cnt; e.bias = m_bias;
    sb_q.push_back(e);
  endtask

  // Wait for the result, compare it, hold it for `hold` cycles, then complete the handshake
  task automatic take_result(input string tag, input int hold, input bit start_in_hold,
                             input bit start_at_ack);
    exp_t e;
    int cyc;
    cyc = 0;
    while (!res_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    $display("result %s: sq=%0d max=%0d cnt=%0d (exp %0d/%0d/%0d)",
             tag, sum_sq_err, max_abs_err, err_count, e.sq, e.mx, e.cnt);
    chk({tag, "_sum_sq_err"}, 64'(sum_sq_err), 64'(e.sq));
    chk({tag, "_max_abs_err"}, 64'(max_abs_err), 64'(e.mx));
    chk({tag, "_err_count"}, 64'(err_count), 64'(e.cnt));
`ifdef ERR_BIAS_EN
    chk({tag, "_err_bias"}, 64'(err_bias), 64'(e.bias));
`endif
    chk({tag, "_in_ready_report"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy_report"}, 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      if (i == 0 && start_in_hold) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_hold_res_valid"}, 64'(res_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_sq"}, 64'(sum_sq_err), 64'(e.sq));
      chk({tag, "_hold_cnt"}, 64'(err_count), 64'(e.cnt));
    end
    res_ready = 1'b1;
    start = start_at_ack;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_ack_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_ack_busy"}, 64'(busy), 64'd0);
    chk({tag, "_persist_sq"}, 64'(sum_sq_err), 64'(e.sq));
    chk({tag, "_persist_max"}, 64'(max_abs_err), 64'(e.mx));
    @(negedge clk);
    chk({tag, "_res_valid_once"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; approx_sum = '0;
    model_clear();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sq", 64'(sum_sq_err), 64'd0);
    chk("rst_max", 64'(max_abs_err), 64'd0);
    chk("rst_cnt", 64'(err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: exact adder
    open_window();
    for (int i = 0; i < 4; i++) send(3, 5, 8);
    push_expected();
    take_result("exact", 0, 1'b0, 1'b0);

    // 2: worst case, plus a check of the two-cycle latency on the first sample
    open_window();
    send(255, 255, 0);
    chk("lat_t1_sq", 64'(sum_sq_err), 64'd0);
    @(negedge clk);
    chk("lat_t2_sq", 64'(sum_sq_err), 64'd260100);
    for (int i = 0; i < 3; i++) send(255, 255, 0);
    push_expected();
    chk("worst_model_sq", 64'(m_sq), 64'd1040400);
    take_result("worst", 0, 1'b0, 1'b0);

    // 3: mixed errors +1, -2, 0, +3
    open_window();
    send(10, 20, 31);
    send(10, 20, 28);
    send(10, 20, 30);
    send(10, 20, 33);
    push_expected();
    take_result("mixed", 0, 1'b0, 1'b0);

    // 4: gaps in in_valid, then res_ready held low for 10 cycles
    open_window();
    for (int i = 0; i < 4; i++) begin
      send(100 + i, 7, 100 + i + 7 + i);
      if (i < 3) chk("gap_in_ready_open", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    chk("gap_window_closed", 64'(in_ready), 64'd0);
    push_expected();
    take_result("backpressure", 10, 1'b0, 1'b0);

    // 5: start during COLLECT is ignored; start during REPORT and at the ack are ignored
    open_window();
    send(1, 2, 4);
    send(50, 60, 100);
    last_sq = m_sq;
    pulse_start();
    chk("start_in_collect_busy", 64'(busy), 64'd1);
    chk("start_in_collect_sq", 64'(sum_sq_err), 64'(last_sq));
    send(0, 0, 0);
    send(200, 55, 256);
    push_expected();
    take_result("protocol", 2, 1'b1, 1'b1);

    // 6: reset after two samples aborts the window
    open_window();
    send(9, 9, 0);
    send(9, 9, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_sq", 64'(sum_sq_err), 64'd0);
    chk("midrst_max", 64'(max_abs_err), 64'd0);
    chk("midrst_cnt", 64'(err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    open_window();
    send(4, 4, 10);
    send(4, 4, 8);
    send(4, 4, 5);
    send(4, 4, 8);
    push_expected();
    take_result("after_reset", 0, 1'b0, 1'b0);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
